csr_file: RTL
=============

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file: the write/commit end of the execute-stage CSR datapath.
//  Supplies CSRRead_D to the pipeline and commits the new CSR value (result1_Atom, pipelined to W) at writeback.
//  Owns the mcycle/minstret counters, trap entry and mret state.
//  Drives the front-end redirect (mtvec on trap, mepc on mret).
// PARAMETERS
//  N         64                     data width; fixed 64 (RV64)
//  HARTID    0                      value returned by mhartid
//  MISA_VAL  64'h8000_0000_0000_0101 misa read value (MXL=2, A, I)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  csrAddr_D    in   12  CSR address being read in decode
//  csrAcc_D     in   1   decode instruction is a CSR op
//  csrWrInt_D   in   1   decode CSR op intends a write (csrrw, or rs1/uimm != 0)
//  CSRRead_D    out  N   read data for csrAddr_D (combinational)
//  illegalCsr_D out  1   csrAcc_D && (unimplemented addr || (csrWrInt_D && addr[11:10]==2'b11))
//  csrWrEn_W    in   1   commit CSR write this cycle
//  csrAddr_W    in   12  CSR write address
//  csrWData_W   in   N   new CSR value (result1_Atom from execute)
//  instRet_W    in   1   an instruction retires this cycle
//  exc_W        in   1   exception at writeback
//  excCause_W   in   4   exception code
//  excPC_W      in   N   PC of faulting instruction
//  excTval_W    in   N   trap value
//  mret_W       in   1   mret retires this cycle
//  redirect_W   out  1   exc_W || mret_W (combinational)
//  redirectPC_W out  N   exc_W ? mtvec : mepc (current register values)
//  mie_o        out  1   mstatus.MIE
// BEHAVIOUR
//  Implemented: mstatus 300, misa 301 (RO), mscratch 340, mtvec 305, mepc 341, mcause 342,
//   mtval 343, mcycle B00, minstret B02, cycle C00 (RO), instret C02 (RO), mhartid F14 (RO).
//  Reset (async, immediate): mstatus = MPP(12:11)=2'b11, all else 0; mtvec/mepc/mcause/mtval/
//   mscratch/mcycle/minstret = 0. Reset mid-trap discards the trap; outputs follow reset state.
//  mstatus: only MIE(3), MPIE(7) writable; MPP reads 2'b11; other bits read 0.
//  Write masks: mtvec[1:0] and mepc[1:0] forced 0; mcause keeps bit 63 and [3:0], rest 0.
//  Read: combinational mux on csrAddr_D; unimplemented addresses read 0.
//   Bypass: if csrWrEn_W && csrAddr_W==csrAddr_D && writable, CSRRead_D returns the masked csrWData_W.
//   Bypassing mcycle/minstret/cycle/instret returns the masked value, not +1.
//  Writes to read-only or unimplemented addresses at W are silently dropped.
//  Latency: W-stage writes are visible in registers next cycle; same cycle via bypass.
//  mcycle: +1 every cycle, wraps 2^64-1 -> 0. minstret: +1 when instRet_W.
//   A same-cycle CSR write to either overrides the increment (value = written data).
//  cycle/instret alias mcycle/minstret.
//  Trap (exc_W=1): mepc<=excPC_W&~3, mcause<={60'b0,excCause_W}, mtval<=excTval_W,
//   MPIE<=MIE, MIE<=0. A faulting instruction does not retire: any csrWrEn_W
//   and instRet_W in that cycle are ignored.
//  mret (mret_W=1, exc_W=0): MIE<=MPIE, MPIE<=1. exc_W && mret_W: exception wins.
//  Redirect uses pre-edge register values: a same-cycle write to mtvec/mepc does not affect redirectPC_W.
//  No FSM beyond the registers; all sequential state updates on the rising edge of clk.
// TESTING
//  Reset, read 300/301/F14 -> 0x1800 / MISA_VAL / HARTID; mcycle reads 1,2,3 on successive cycles.
//  W write 340=0xDEAD with D reading 340 same cycle -> CSRRead_D=0xDEAD; next cycle register=0xDEAD.
//  mtvec<=0x8003, MIE=1, then exc_W cause 2, PC 0x1006 -> redirectPC=0x8000;
//   next cycle mepc=0x1004, mcause=2, MIE=0, MPIE=1.
//  mret_W after trap -> redirectPC=0x1004; next cycle MIE=1, MPIE=1.
//  exc_W with csrWrEn_W to 340 and instRet_W -> mscratch unchanged, minstret unchanged.
//  Write mcycle=0xFFFF_FFFF_FFFF_FFFF -> 0 the following cycle.
//  csrAcc_D+csrWrInt_D to C00 -> illegalCsr_D=1; read-only access to C00 -> 0.
//  Unimplemented 7C0 -> illegalCsr_D=1, read 0.

Source files
------------

// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file -- machine-mode CSR register file (RV64)
//
// Supplies CSR read data to decode and commits new CSR values at writeback.
// It owns mcycle/minstret, performs trap entry and mret, and produces the
// front-end redirect target (mtvec on a trap, mepc on an mret).
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   csrAddr_D        CSR address read in decode
//   csrAcc_D         decode instruction is a CSR op
//   csrWrInt_D       decode CSR op intends to write
//   CSRRead_D        combinational read data, with bypass from W
//   illegalCsr_D     unimplemented address, or write intent to a read-only one
//   csrWrEn_W        commit a CSR write this cycle
//   csrAddr_W        CSR write address
//   csrWData_W       new CSR value
//   instRet_W        an instruction retires this cycle
//   exc_W            exception at writeback
//   excCause_W       exception code
//   excPC_W          PC of the faulting instruction
//   excTval_W        trap value
//   mret_W           mret retires this cycle
//   redirect_W       front-end redirect request
//   redirectPC_W     redirect target (pre-edge mtvec or mepc)
//   mie_o            mstatus.MIE
// ---------------------------------------------------------------------------
module csr_file #(
    parameter int          N        = 64,
    parameter logic [63:0] HARTID   = 64'd0,
    parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_0101
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [11:0]  csrAddr_D,
    input  logic         csrAcc_D,
    input  logic         csrWrInt_D,
    output logic [N-1:0] CSRRead_D,
    output logic         illegalCsr_D,
    input  logic         csrWrEn_W,
    input  logic [11:0]  csrAddr_W,
    input  logic [N-1:0] csrWData_W,
    input  logic         instRet_W,
    input  logic         exc_W,
    input  logic [3:0]   excCause_W,
    input  logic [N-1:0] excPC_W,
    input  logic [N-1:0] excTval_W,
    input  logic         mret_W,
    output logic         redirect_W,
    output logic [N-1:0] redirectPC_W,
    output logic         mie_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    logic         mie_reg;
    logic         mpie_reg;
    logic [N-1:0] mtvec_reg;
    logic [N-1:0] mscratch_reg;
    logic [N-1:0] mepc_reg;
    logic [N-1:0] mcause_reg;
    logic [N-1:0] mtval_reg;
    logic [N-1:0] mcycle_reg;
    logic [N-1:0] minstret_reg;

    // mstatus as seen by software: MPP is hardwired to M-mode.
    logic [N-1:0] mstatus_val;
    assign mstatus_val = {51'b0, 2'b11, 3'b0, mpie_reg, 3'b0, mie_reg, 3'b0};

    // A faulting instruction does not retire, so its CSR write is squashed.
    logic wr_en;
    assign wr_en = csrWrEn_W && !exc_W;

    // Writable registers only; read-only and unimplemented addresses drop writes.
    logic w_writable;
    always_comb begin
        w_writable = 1'b0;
        case (csrAddr_W)
            A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MTVAL, A_MCYCLE, A_MINSTRET: w_writable = 1'b1;
            default: w_writable = 1'b0;
        endcase
    end

    // Value the written register will read back as after masking.
    logic [N-1:0] w_masked;
    always_comb begin
        w_masked = csrWData_W;
        case (csrAddr_W)
            A_MSTATUS: w_masked = {51'b0, 2'b11, 3'b0, csrWData_W[7], 3'b0, csrWData_W[3], 3'b0};
            A_MTVEC,
            A_MEPC:    w_masked = {csrWData_W[N-1:2], 2'b00};
            A_MCAUSE:  w_masked = {csrWData_W[N-1], 59'b0, csrWData_W[3:0]};
            default:   w_masked = csrWData_W;
        endcase
    end

    // Decode read mux; the user counters alias the machine counters, so they
    // are folded onto the machine address for bypass matching.
    logic [N-1:0] reg_rd;
    logic         d_impl;
    logic [11:0]  d_canon;
    always_comb begin
        reg_rd  = '0;
        d_impl  = 1'b1;
        d_canon = csrAddr_D;
        case (csrAddr_D)
            A_MSTATUS:  reg_rd = mstatus_val;
            A_MISA:     reg_rd = MISA_VAL;
            A_MTVEC:    reg_rd = mtvec_reg;
            A_MSCRATCH: reg_rd = mscratch_reg;
            A_MEPC:     reg_rd = mepc_reg;
            A_MCAUSE:   reg_rd = mcause_reg;
            A_MTVAL:    reg_rd = mtval_reg;
            A_MCYCLE:   reg_rd = mcycle_reg;
            A_MINSTRET: reg_rd = minstret_reg;
            A_CYCLE: begin
                reg_rd  = mcycle_reg;
                d_canon = A_MCYCLE;
            end
            A_INSTRET: begin
                reg_rd  = minstret_reg;
                d_canon = A_MINSTRET;
            end
            A_MHARTID:  reg_rd = HARTID;
            default: begin
                reg_rd = '0;
                d_impl = 1'b0;
            end
        endcase
    end

    // Bypass returns the value the register will hold, not the counter +1.
    assign CSRRead_D = (csrWrEn_W && w_writable && d_canon == csrAddr_W) ? w_masked : reg_rd;

    assign illegalCsr_D = csrAcc_D && (!d_impl || (csrWrInt_D && csrAddr_D[11:10] == 2'b11));

    assign redirect_W   = exc_W || mret_W;
    assign redirectPC_W = exc_W ? mtvec_reg : mepc_reg;
    assign mie_o        = mie_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mtvec_reg    <= '0;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mtval_reg    <= '0;
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            // Counters: an explicit write overrides the increment.
            if (wr_en && csrAddr_W == A_MCYCLE)
                mcycle_reg <= csrWData_W;
            else
                mcycle_reg <= mcycle_reg + 1'b1;

            if (wr_en && csrAddr_W == A_MINSTRET)
                minstret_reg <= csrWData_W;
            else if (instRet_W && !exc_W)
                minstret_reg <= minstret_reg + 1'b1;

            if (wr_en) begin
                case (csrAddr_W)
                    A_MSTATUS: begin
                        mie_reg  <= csrWData_W[3];
                        mpie_reg <= csrWData_W[7];
                    end
                    A_MTVEC:    mtvec_reg    <= w_masked;
                    A_MSCRATCH: mscratch_reg <= csrWData_W;
                    A_MEPC:     mepc_reg     <= w_masked;
                    A_MCAUSE:   mcause_reg   <= w_masked;
                    A_MTVAL:    mtval_reg    <= csrWData_W;
                    default: ;
                endcase
            end

            // Trap entry / mret come last so they take precedence over a
            // same-cycle mstatus write; an exception beats mret.
            if (exc_W) begin
                mepc_reg   <= {excPC_W[N-1:2], 2'b00};
                mcause_reg <= {60'b0, excCause_W};
                mtval_reg  <= excTval_W;
                mpie_reg   <= mie_reg;
                mie_reg    <= 1'b0;
            end else if (mret_W) begin
                mie_reg  <= mpie_reg;
                mpie_reg <= 1'b1;
            end
        end
    end

endmodule
